// File: rtl/cpu_io_host.sv
// ---------------------------------------------------------------------------
// cpu_io_host
//
// Purpose:
//   Host-side counterpart of the CPU data I/O port. A host-loaded source FIFO
//   feeds the CPU's Din/Sample inputs at a fixed sample rate. A change-detecting
//   capture FIFO records each new value the CPU presents on Dout/Dval, and the
//   host drains it.
//
// Parameters:
//   DEPTH  entries per FIFO (power of two, >= 2)
//   RATE   clock cycles between sample opportunities (>= 2)
//
// Ports:
//   Clock     in   system clock, rising-edge active
//   Reset     in   asynchronous active-low reset
//   WrData    in   8-bit sample value from the host
//   WrEn      in   push WrData into the source FIFO
//   WrFull    out  source FIFO full
//   Din       out  8-bit two's-complement sample to the CPU (registered)
//   Sample    out  one-cycle strobe marking a new Din
//   Dout      in   CPU data output
//   Dval      in   CPU data-valid qualifier
//   RdEn      in   pop the capture FIFO head
//   RdData    out  capture FIFO head (show-ahead), 0 when empty
//   RdValid   out  capture FIFO non-empty
//   Ovf       out  sticky: a capture was dropped because the FIFO was full
//   Starve    out  sticky: a sample tick found the source FIFO empty
//   ClrFlags  in   clear Ovf and Starve (a same-edge set wins)
// ---------------------------------------------------------------------------
module cpu_io_host #(
   parameter int DEPTH = 16,
   parameter int RATE  = 12500000
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic [7:0] WrData,
   input  logic       WrEn,
   output logic       WrFull,
   output logic [7:0] Din,
   output logic       Sample,
   input  logic [7:0] Dout,
   input  logic       Dval,
   input  logic       RdEn,
   output logic [7:0] RdData,
   output logic       RdValid,
   output logic       Ovf,
   output logic       Starve,
   input  logic       ClrFlags
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = (RATE > 1) ? $clog2(RATE) : 1;
   localparam logic [CW-1:0] RATE_LAST = CW'(RATE - 1);
   localparam logic [AW:0]   PTR_ONE   = (AW + 1)'(1);

   // Rate counter
   logic [CW-1:0] r_rateCnt;
   logic          w_tick;

   // Source FIFO
   logic [7:0]    r_srcMem [DEPTH];
   logic [AW:0]   r_srcWrPtr;
   logic [AW:0]   r_srcRdPtr;
   logic          w_srcFull;
   logic          w_srcEmpty;
   logic          w_srcPush;
   logic          w_srcPop;

   // Sample output registers
   logic [7:0]    r_din;
   logic          r_sample;

   // Capture FIFO and change detector
   logic [7:0]    r_capMem [DEPTH];
   logic [AW:0]   r_capWrPtr;
   logic [AW:0]   r_capRdPtr;
   logic          w_capFull;
   logic          w_capEmpty;
   logic          w_capAttempt;
   logic          w_capPush;
   logic          w_capPop;
   logic [7:0]    r_last;
   logic          r_armed;

   // Sticky flags
   logic          r_ovf;
   logic          r_starve;
   logic          w_ovfSet;
   logic          w_starveSet;

   // ------------------------------------------------------------------------
   // Free-running rate counter. A tick is the edge at which the counter sits
   // at its terminal value, so the first tick after reset is edge RATE.
   // ------------------------------------------------------------------------
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         r_rateCnt <= '0;
      end else if (w_tick) begin
         r_rateCnt <= '0;
      end else begin
         r_rateCnt <= r_rateCnt + CW'(1);
      end
   end

   assign w_tick = (r_rateCnt == RATE_LAST);

   // ------------------------------------------------------------------------
   // Occupancy is decoded from the registered pointers only, so every push,
   // pop and tick decision uses pre-edge state: a same-edge pop never frees
   // room for a push, and a same-edge push into an empty FIFO is not visible
   // to a pop or tick. The extra MSB separates full from empty.
   // ------------------------------------------------------------------------
   always_comb begin
      w_srcEmpty = (r_srcWrPtr == r_srcRdPtr);
      w_srcFull  = (r_srcWrPtr[AW] != r_srcRdPtr[AW]) &&
                   (r_srcWrPtr[AW-1:0] == r_srcRdPtr[AW-1:0]);
      w_capEmpty = (r_capWrPtr == r_capRdPtr);
      w_capFull  = (r_capWrPtr[AW] != r_capRdPtr[AW]) &&
                   (r_capWrPtr[AW-1:0] == r_capRdPtr[AW-1:0]);
   end

   // Source-side decisions: host writes into a full FIFO are dropped, and a
   // tick either pops the head or records starvation.
   always_comb begin
      w_srcPush   = WrEn && !w_srcFull;
      w_srcPop    = w_tick && !w_srcEmpty;
      w_starveSet = w_tick && w_srcEmpty;
   end

   // Capture-side decisions: an attempt is made on the first valid value
   // after reset or whenever the valid value differs from the last one seen.
   // A full FIFO turns the attempt into an overflow instead of a push.
   always_comb begin
      w_capAttempt = Dval && (r_armed || (Dout != r_last));
      w_capPush    = w_capAttempt && !w_capFull;
      w_ovfSet     = w_capAttempt && w_capFull;
      w_capPop     = RdEn && !w_capEmpty;
   end

   // ------------------------------------------------------------------------
   // FIFO storage arrays. They carry no reset: the pointers alone decide
   // what is valid, so clearing the pointers discards the contents.
   // ------------------------------------------------------------------------
   always_ff @(posedge Clock) begin
      if (w_srcPush) begin
         r_srcMem[r_srcWrPtr[AW-1:0]] <= WrData;
      end
      if (w_capPush) begin
         r_capMem[r_capWrPtr[AW-1:0]] <= Dout;
      end
   end

   // Source FIFO pointers.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         r_srcWrPtr <= '0;
         r_srcRdPtr <= '0;
      end else begin
         if (w_srcPush) begin
            r_srcWrPtr <= r_srcWrPtr + PTR_ONE;
         end
         if (w_srcPop) begin
            r_srcRdPtr <= r_srcRdPtr + PTR_ONE;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Din only moves on a tick that actually pops, and Sample is the matching
   // one-cycle strobe. A starved tick leaves Din holding its last value.
   // ------------------------------------------------------------------------
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         r_din    <= 8'h00;
         r_sample <= 1'b0;
      end else begin
         r_sample <= w_srcPop;
         if (w_srcPop) begin
            r_din <= r_srcMem[r_srcRdPtr[AW-1:0]];
         end
      end
   end

   // Capture FIFO pointers.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         r_capWrPtr <= '0;
         r_capRdPtr <= '0;
      end else begin
         if (w_capPush) begin
            r_capWrPtr <= r_capWrPtr + PTR_ONE;
         end
         if (w_capPop) begin
            r_capRdPtr <= r_capRdPtr + PTR_ONE;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Change detector state. The last value is updated on every attempt,
   // including a dropped one, so an overflowed value is not retried on the
   // following cycles. With Dval low nothing moves.
   // ------------------------------------------------------------------------
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         r_last  <= 8'h00;
         r_armed <= 1'b1;
      end else if (w_capAttempt) begin
         r_last  <= Dout;
         r_armed <= 1'b0;
      end
   end

   // ------------------------------------------------------------------------
   // Sticky status flags. The set term is checked before the clear term so
   // an event on the same edge as ClrFlags is not lost.
   // ------------------------------------------------------------------------
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         r_ovf    <= 1'b0;
         r_starve <= 1'b0;
      end else begin
         if (w_ovfSet) begin
            r_ovf <= 1'b1;
         end else if (ClrFlags) begin
            r_ovf <= 1'b0;
         end
         if (w_starveSet) begin
            r_starve <= 1'b1;
         end else if (ClrFlags) begin
            r_starve <= 1'b0;
         end
      end
   end

   // Outputs. RdData is forced to zero when empty so stale storage never
   // leaks out after a reset or a full drain.
   assign WrFull  = w_srcFull;
   assign Din     = r_din;
   assign Sample  = r_sample;
   assign RdValid = !w_capEmpty;
   assign RdData  = w_capEmpty ? 8'h00 : r_capMem[r_capRdPtr[AW-1:0]];
   assign Ovf     = r_ovf;
   assign Starve  = r_starve;

endmodule

// File: tb/tb_cpu_io_host.sv
// ---------------------------------------------------------------------------
// tb_cpu_io_host
//
// Directed bench for cpu_io_host with RATE=4 and DEPTH=4. Inputs change on
// the falling edge and outputs are read on the falling edge, so edge k below
// always means the k-th rising edge after reset release.
// ---------------------------------------------------------------------------
module tb_cpu_io_host;

   localparam int DEPTH = 4;
   localparam int RATE  = 4;

   logic       Clock = 1'b0;
   logic       Reset;
   logic [7:0] WrData;
   logic       WrEn;
   logic       WrFull;
   logic [7:0] Din;
   logic       Sample;
   logic [7:0] Dout;
   logic       Dval;
   logic       RdEn;
   logic [7:0] RdData;
   logic       RdValid;
   logic       Ovf;
   logic       Starve;
   logic       ClrFlags;

   int checks   = 0;
   int failures = 0;

   cpu_io_host #(.DEPTH(DEPTH), .RATE(RATE)) dut (
      .Clock    (Clock),
      .Reset    (Reset),
      .WrData   (WrData),
      .WrEn     (WrEn),
      .WrFull   (WrFull),
      .Din      (Din),
      .Sample   (Sample),
      .Dout     (Dout),
      .Dval     (Dval),
      .RdEn     (RdEn),
      .RdData   (RdData),
      .RdValid  (RdValid),
      .Ovf      (Ovf),
      .Starve   (Starve),
      .ClrFlags (ClrFlags)
   );

   // 10-unit clock period, rising edges at 5, 15, 25, ...
   always #5 Clock = ~Clock;

   // Hard time limit so a broken design can never hang the run.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog expired got=running exp=finished");
      $fatal(1, "[TB] watchdog");
   end

   // Put every host input into its idle level.
   task automatic idleInputs();
      WrData   = 8'h00;
      WrEn     = 1'b0;
      Dout     = 8'h00;
      Dval     = 1'b0;
      RdEn     = 1'b0;
      ClrFlags = 1'b0;
   endtask

   // Assert reset for two falling edges; the caller releases it at a
   // falling edge so the next rising edge is edge 1.
   task automatic holdReset();
      Reset = 1'b0;
      @(negedge Clock);
      @(negedge Clock);
   endtask

   // Outputs while reset is held, then a few idle cycles after release.
   task automatic test_reset();
      idleInputs();
      holdReset();
      if (Din !== 8'h00) begin failures++; $display("[TB] FAIL reset_din got=%h exp=00", Din); end
      checks++;
      if (Sample !== 1'b0) begin failures++; $display("[TB] FAIL reset_sample got=%b exp=0", Sample); end
      checks++;
      if (WrFull !== 1'b0) begin failures++; $display("[TB] FAIL reset_wrfull got=%b exp=0", WrFull); end
      checks++;
      if (RdData !== 8'h00) begin failures++; $display("[TB] FAIL reset_rddata got=%h exp=00", RdData); end
      checks++;
      if (RdValid !== 1'b0) begin failures++; $display("[TB] FAIL reset_rdvalid got=%b exp=0", RdValid); end
      checks++;
      if (Ovf !== 1'b0) begin failures++; $display("[TB] FAIL reset_ovf got=%b exp=0", Ovf); end
      checks++;
      if (Starve !== 1'b0) begin failures++; $display("[TB] FAIL reset_starve got=%b exp=0", Starve); end
      checks++;
      Reset = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         @(negedge Clock);
         if (Sample !== 1'b0 || Starve !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_idle k=%0d got=%b%b exp=00", k, Sample, Starve);
         end
         checks++;
      end
   endtask

   // Three writes on edges 1..3, samples at ticks 4, 8, 12, starvation at 16.
   task automatic test_source_streaming();
      logic [7:0] expDin;
      logic       expSample;
      logic       expStarve;
      idleInputs();
      holdReset();
      Reset  = 1'b1;
      WrEn   = 1'b1;
      WrData = 8'h05;
      for (int k = 1; k <= 16; k++) begin
         @(negedge Clock);
         expSample = (k == 4) || (k == 8) || (k == 12);
         expDin    = (k < 4) ? 8'h00 : (k < 8) ? 8'h05 : (k < 12) ? 8'hFB : 8'h7F;
         expStarve = (k >= 16);
         if (Din !== expDin) begin failures++; $display("[TB] FAIL stream_din k=%0d got=%h exp=%h", k, Din, expDin); end
         checks++;
         if (Sample !== expSample) begin failures++; $display("[TB] FAIL stream_sample k=%0d got=%b exp=%b", k, Sample, expSample); end
         checks++;
         if (Starve !== expStarve) begin failures++; $display("[TB] FAIL stream_starve k=%0d got=%b exp=%b", k, Starve, expStarve); end
         checks++;
         WrEn   = (k + 1 <= 3);
         WrData = (k == 1) ? 8'hFB : (k == 2) ? 8'h7F : 8'h00;
      end
   endtask

   // Five writes on edges 4..8: the fifth meets a full FIFO on the tick edge
   // (the pop does not make room), so only 0x01..0x04 are ever emitted.
   task automatic test_source_full();
      logic [7:0] expDin;
      logic       expSample;
      logic       expFull;
      idleInputs();
      holdReset();
      Reset = 1'b1;
      for (int k = 1; k <= 24; k++) begin
         @(negedge Clock);
         expSample = (k == 8) || (k == 12) || (k == 16) || (k == 20);
         expFull   = (k == 7);
         expDin    = (k < 8) ? 8'h00 : (k < 12) ? 8'h01 : (k < 16) ? 8'h02 :
                     (k < 20) ? 8'h03 : 8'h04;
         if (Din !== expDin) begin failures++; $display("[TB] FAIL full_din k=%0d got=%h exp=%h", k, Din, expDin); end
         checks++;
         if (Sample !== expSample) begin failures++; $display("[TB] FAIL full_sample k=%0d got=%b exp=%b", k, Sample, expSample); end
         checks++;
         if (WrFull !== expFull) begin failures++; $display("[TB] FAIL full_wrfull k=%0d got=%b exp=%b", k, WrFull, expFull); end
         checks++;
         WrEn   = (k + 1 >= 4) && (k + 1 <= 8);
         WrData = 8'(k - 2);
      end
      WrEn = 1'b0;
   endtask

   // Dout=0x00 held valid from reset, then 0x12 for ten cycles: two entries.
   task automatic test_change_detect();
      idleInputs();
      Dval = 1'b1;
      Dout = 8'h00;
      holdReset();
      Reset = 1'b1;
      @(negedge Clock);
      if (RdValid !== 1'b1 || RdData !== 8'h00) begin
         failures++; $display("[TB] FAIL chg_first got=%b/%h exp=1/00", RdValid, RdData);
      end
      checks++;
      repeat (2) @(negedge Clock);
      Dout = 8'h12;
      repeat (10) @(negedge Clock);
      if (RdValid !== 1'b1 || RdData !== 8'h00) begin
         failures++; $display("[TB] FAIL chg_head got=%b/%h exp=1/00", RdValid, RdData);
      end
      checks++;
      RdEn = 1'b1;
      @(negedge Clock);
      if (RdValid !== 1'b1 || RdData !== 8'h12) begin
         failures++; $display("[TB] FAIL chg_second got=%b/%h exp=1/12", RdValid, RdData);
      end
      checks++;
      @(negedge Clock);
      if (RdValid !== 1'b0 || RdData !== 8'h00) begin
         failures++; $display("[TB] FAIL chg_empty got=%b/%h exp=0/00", RdValid, RdData);
      end
      checks++;
      @(negedge Clock);
      if (RdValid !== 1'b0 || Ovf !== 1'b0) begin
         failures++; $display("[TB] FAIL chg_rd_empty got=%b/%b exp=0/0", RdValid, Ovf);
      end
      checks++;
      RdEn = 1'b0;
   endtask

   // Dval low blocks capture; raising it captures 0x33 once.
   task automatic test_dval_gating();
      Dval = 1'b0;
      Dout = 8'h33;
      for (int k = 1; k <= 5; k++) begin
         @(negedge Clock);
         if (RdValid !== 1'b0) begin failures++; $display("[TB] FAIL gate_idle k=%0d got=%b exp=0", k, RdValid); end
         checks++;
      end
      Dval = 1'b1;
      @(negedge Clock);
      if (RdValid !== 1'b1 || RdData !== 8'h33) begin
         failures++; $display("[TB] FAIL gate_capture got=%b/%h exp=1/33", RdValid, RdData);
      end
      checks++;
      RdEn = 1'b1;
      @(negedge Clock);
      if (RdValid !== 1'b0) begin failures++; $display("[TB] FAIL gate_single got=%b exp=0", RdValid); end
      checks++;
      RdEn = 1'b0;
      Dval = 1'b0;
   endtask

   // Five distinct values with no reads: four stored, overflow flagged.
   // Flags are then cleared at edge 10, and a clear on tick edge 12 with an
   // empty source FIFO loses to the starvation set.
   task automatic test_capture_overflow();
      idleInputs();
      holdReset();
      Reset = 1'b1;
      Dval  = 1'b1;
      Dout  = 8'h10;
      for (int k = 1; k <= 5; k++) begin
         @(negedge Clock);
         if (k == 4) begin
            if (Ovf !== 1'b0) begin failures++; $display("[TB] FAIL ovf_early got=%b exp=0", Ovf); end
            checks++;
         end
         Dout = 8'h10 + 8'(k);
      end
      if (Ovf !== 1'b1) begin failures++; $display("[TB] FAIL ovf_set got=%b exp=1", Ovf); end
      checks++;
      if (RdData !== 8'h10) begin failures++; $display("[TB] FAIL ovf_head got=%h exp=10", RdData); end
      checks++;
      Dval = 1'b0;
      RdEn = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         @(negedge Clock);
         if (i < 4) begin
            if (RdValid !== 1'b1 || RdData !== 8'h10 + 8'(i)) begin
               failures++; $display("[TB] FAIL ovf_read i=%0d got=%b/%h exp=1/%h", i, RdValid, RdData, 8'h10 + 8'(i));
            end
         end else begin
            if (RdValid !== 1'b0) begin failures++; $display("[TB] FAIL ovf_drained got=%b exp=0", RdValid); end
         end
         checks++;
      end
      RdEn     = 1'b0;
      ClrFlags = 1'b1;
      @(negedge Clock);
      if (Ovf !== 1'b0 || Starve !== 1'b0) begin
         failures++; $display("[TB] FAIL clr_flags got=%b/%b exp=0/0", Ovf, Starve);
      end
      checks++;
      ClrFlags = 1'b0;
      @(negedge Clock);
      ClrFlags = 1'b1;
      @(negedge Clock);
      if (Starve !== 1'b1 || Ovf !== 1'b0) begin
         failures++; $display("[TB] FAIL clr_set_wins got=%b/%b exp=1/0", Starve, Ovf);
      end
      checks++;
      ClrFlags = 1'b0;
   endtask

   // Reset asserted between edges with two entries in each FIFO.
   task automatic test_async_reset();
      idleInputs();
      holdReset();
      Reset  = 1'b1;
      WrEn   = 1'b1;
      WrData = 8'hAA;
      Dval   = 1'b1;
      Dout   = 8'h21;
      @(negedge Clock);
      WrData = 8'hBB;
      Dout   = 8'h22;
      @(negedge Clock);
      WrData = 8'hCC;
      Dval   = 1'b0;
      @(negedge Clock);
      WrEn = 1'b0;
      @(negedge Clock);
      if (Din !== 8'hAA || Sample !== 1'b1 || RdValid !== 1'b1 || RdData !== 8'h21) begin
         failures++; $display("[TB] FAIL arst_pre got=%h/%b/%b/%h exp=aa/1/1/21", Din, Sample, RdValid, RdData);
      end
      checks++;
      #2 Reset = 1'b0;
      #1;
      if (Din !== 8'h00 || Sample !== 1'b0 || WrFull !== 1'b0) begin
         failures++; $display("[TB] FAIL arst_src got=%h/%b/%b exp=00/0/0", Din, Sample, WrFull);
      end
      checks++;
      if (RdData !== 8'h00 || RdValid !== 1'b0 || Ovf !== 1'b0 || Starve !== 1'b0) begin
         failures++; $display("[TB] FAIL arst_cap got=%h/%b/%b/%b exp=00/0/0/0", RdData, RdValid, Ovf, Starve);
      end
      checks++;
      @(negedge Clock);
      Reset = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         @(negedge Clock);
         if (Sample !== 1'b0 || RdValid !== 1'b0 || Din !== 8'h00) begin
            failures++; $display("[TB] FAIL arst_after k=%0d got=%b/%b/%h exp=0/0/00", k, Sample, RdValid, Din);
         end
         checks++;
      end
   endtask

   initial begin
      idleInputs();
      Reset = 1'b0;
      test_reset();
      test_source_streaming();
      test_source_full();
      test_change_detect();
      test_dval_gating();
      test_capture_overflow();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cpu_io_host.md
# cpu_io_host

Host-side counterpart of the CPU's data I/O port. Feeds the CPU's `Din`/`Sample` inputs from a host-loaded sample FIFO at a fixed sample rate. It also captures every new value the CPU presents on `Dout`/`Dval` into a capture FIFO that the host drains. It sits between the board/testbench host logic and the CPU data pins, and replaces hand-driven switches and LEDs for stimulus and observation.

## Interface
Parameters:
- `DEPTH`, 16: entries per FIFO. Must be a power of two and ≥2.
- `RATE`, 12500000: clock cycles between sample opportunities. Must be ≥2.

Ports:
- `Clock`  in  1  single system clock; all state changes on its rising edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `WrData`  in  8  sample value written by the host.
- `WrEn`  in  1  push `WrData` into the source FIFO.
- `WrFull`  out  1  source FIFO full.
- `Din`  out  8  signed sample presented to the CPU. Registered.
- `Sample`  out  1  one-cycle strobe marking a new `Din`.
- `Dout`  in  8  CPU data output.
- `Dval`  in  1  CPU data-valid qualifier.
- `RdEn`  in  1  pop the head of the capture FIFO.
- `RdData`  out  8  capture FIFO head (show-ahead). 0 when empty.
- `RdValid`  out  1  capture FIFO non-empty.
- `Ovf`  out  1  sticky flag: a capture was dropped because the FIFO was full.
- `Starve`  out  1  sticky flag: a sample tick occurred while the source FIFO was empty.
- `ClrFlags`  in  1  clears `Ovf` and `Starve`.

## Operation
- Reset (`Reset`=0, asynchronous) forces the following, immediately and independent of `Clock`:
  - `Din`=0, `Sample`=0, `WrFull`=0, `RdData`=0, `RdValid`=0, `Ovf`=0, `Starve`=0.
  - Rate counter = 0, both FIFOs empty, change detector armed.
  - Reset mid-operation discards all FIFO contents.
- Rate counter:
  - Free-running 0..`RATE`-1, wraps to 0.
  - A "tick" is any edge at which the counter equals `RATE`-1.
- Source path:
  - Tick with the source FIFO non-empty: `Din`←head, pop, `Sample`=1 for exactly the following cycle.
  - Tick with the source FIFO empty: `Sample` stays 0, `Din` holds its last value, `Starve`←1.
- Source write:
  - `WrEn`=1 and not full: push `WrData`.
  - `WrEn`=1 and full: the write is dropped silently; the host must observe `WrFull`.
- Capture path (change detector):
  - At each edge with `Dval`=1, `Dout` is pushed if the detector is armed (first capture after reset) or if `Dout` ≠ the last captured value.
  - On every qualifying push attempt, last←`Dout` and the detector disarms.
  - `Dval`=0: no capture; last value and arm state are retained.
  - Capture FIFO full on a push attempt: the value is dropped, `Ovf`←1, and last is still updated, so the same value does not retry.
- Capture read:
  - `RdEn`=1 with `RdValid`=1 pops.
  - `RdEn`=1 when empty is ignored.
- Fullness and emptiness are evaluated from pre-edge state:
  - A simultaneous pop does not make room for a push on the same edge.
  - A push into an empty FIFO is not visible to a pop or tick on that same edge.
- `ClrFlags`: clears both flags at the edge. If a set event occurs on the same edge, set wins.
- Pointers wrap modulo `DEPTH`; full/empty are distinguished by an extra pointer bit.

## Timing
- `WrFull` / `RdValid` update one edge after the push or pop that changes occupancy.
- Write-to-sample:
  - A value written into an empty source FIFO appears at the first tick strictly after the write edge.
  - `Din` and `Sample` are valid in the cycle after that tick edge.
- Samples are spaced exactly `RATE` cycles apart while the source FIFO stays non-empty.
- The first tick after reset release is the `RATE`-th rising edge.
- `Dout` change to `RdValid`: 1 cycle when the capture FIFO is empty. `RdData` is valid in the same cycle as `RdValid`.
- `Din` never changes except at a tick with `Sample` asserted.

## Test plan
All scenarios use `RATE`=4 and `DEPTH`=4.
- **Source streaming.** Write 0x05, 0xFB, 0x7F after reset → `Sample` pulses 4 cycles apart with `Din`=0x05, 0xFB, 0x7F. At the 4th tick, `Starve`=1 and `Din` stays 0x7F.
- **Source full.** Write 5 values 0x01..0x05 back-to-back → `WrFull`=1 after the 4th. Emitted sequence is 0x01..0x04; 0x05 is never emitted.
- **Change detection.** Hold `Dval`=1, `Dout`=0x00 from reset, then `Dout`=0x12 for 10 cycles → exactly two entries, read back as 0x00 then 0x12, then `RdValid`=0.
- **Dval gating.** Set `Dval`=0 and `Dout`=0x33 for 5 cycles → nothing captured. Raise `Dval`=1 → one entry 0x33, `RdValid` high the next cycle.
- **Capture overflow and flag clear.** Present 5 distinct values (0x10..0x14) with no reads → 4 entries 0x10..0x13 and `Ovf`=1. Pulse `ClrFlags` → `Ovf`=0.
- **Asynchronous reset mid-operation.** Drive `Reset` low between edges with both FIFOs holding 2 entries → all outputs go to reset values before the next edge. After release, `RdValid`=0 and no `Sample` occurs until new writes are made.
